// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: drain stage behind the transaction-layer FIFO.
//
// Issues FIFO read strobes whenever there is guaranteed room, absorbs the
// FIFO's one-cycle registered read latency in a 2-entry skid buffer and
// presents the words as a valid/ready stream in strict FIFO order.
//
// Ports
//   clk        rising-edge clock shared with the FIFO
//   rst_n      synchronous active-low reset
//   fifo_empty FIFO empty flag
//   fifo_data  FIFO read data, valid the cycle after fifo_rd
//   fifo_rd    FIFO read strobe
//   enable     1 = new FIFO reads may be issued
//   out_valid  out_data holds a word
//   out_data   head word of the skid buffer
//   out_ready  downstream accepts the word when out_valid=1
//   word_cnt   count of delivered words (wraps)
//   busy       a read is in flight or the buffer holds data

module fifo_pop_ctrl #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    input  logic              enable,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccTwo   = 2'd2
    } occ_e;

    occ_e              occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic       pop;
    // Occupancy after this edge: occ + inflight - pop. occ + inflight never
    // exceeds 2 and pop needs occ >= 1, so 2 bits cannot wrap.
    logic [1:0] level;

    assign pop   = out_valid & out_ready;
    assign level = 2'(occ_q) + {1'b0, inflight_q} - {1'b0, pop};

    // Only read when the word returning next cycle is sure to have a slot.
    // Gated by rst_n so no strobe reaches the FIFO while it is in reset.
    assign fifo_rd = rst_n & enable & ~fifo_empty & (level < 2'd2);

    always_comb begin
        occ_d      = occ_e'(level);
        inflight_d = fifo_rd;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;

        if (pop) begin
            head_d = tail_q;
            cnt_d  = cnt_q + CNT_W'(1);
        end

        // Returning word lands in the first free slot after any pop.
        if (inflight_q) begin
            if (occ_q == OccEmpty || (occ_q == OccOne && pop)) begin
                head_d = fifo_data;
            end else begin
                tail_d = fifo_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q      <= OccEmpty;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = (occ_q != OccEmpty);
    assign out_data  = head_q;
    assign word_cnt  = cnt_q;
    assign busy      = (occ_q != OccEmpty) | inflight_q;

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: a behavioural FIFO feeds the DUT, every word
// pushed into the FIFO is queued as expected output, and a monitor checks
// each delivered word, the delivered-word count and output stability.

module tb_fifo_pop_ctrl;

    localparam int DATA_W = 10;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b1;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_empty;
    logic              fifo_rd;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  word_cnt;
    logic              busy;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_pop_ctrl #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .enable    (enable),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .word_cnt  (word_cnt),
        .busy      (busy)
    );

    // Behavioural FIFO: registered read data, flushed on reset.
    logic [DATA_W-1:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int n_reads = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
            n_reads   <= n_reads + 1;
        end
    end

    // Scoreboard state.
    logic [DATA_W-1:0] exp_q[$];
    logic [CNT_W-1:0]  exp_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_raw(input logic [DATA_W-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        push_raw(v);
        exp_q.push_back(v);
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int k = 0; k < max_cyc && (exp_q.size() != 0 || busy); k++) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    // Monitor: runs on the falling edge, judges what the next rising edge
    // will transfer.
    logic              seen_rst = 1'b0;
    logic              prev_rst = 1'b0;
    logic              hold_prev = 1'b0;
    logic [DATA_W-1:0] held_data = '0;
    logic [DATA_W-1:0] exp_word;

    always @(negedge clk) begin
        if (seen_rst) begin
            if (prev_rst) begin
                chk("rst_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
            end
            chk("word_cnt", word_cnt, exp_cnt);
            if (fifo_empty) chk("rd_while_empty", fifo_rd, 0);
            if (hold_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held_data);
            end
        end
        hold_prev = rst_n && out_valid && !out_ready;
        held_data = out_data;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt  = '0;
            prev_rst = 1'b1;
            seen_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            if (seen_rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL spurious_word: got 0x%0h, expected no word at %0t",
                             out_data, $time);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk("out_data", out_data, exp_word);
                end
                exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        logic [CNT_W-1:0] w0;

        // 1: reset held with a non-empty FIFO and enable=1.
        for (int i = 0; i < 3; i++) begin
            cyc();
            push_raw(DATA_W'(10'h3AA + i));
            @(negedge clk);
            chk("t1_fifo_rd", fifo_rd, 0);
            chk("t1_valid", out_valid, 0);
            chk("t1_cnt", word_cnt, 0);
            chk("t1_busy", busy, 0);
        end
        cyc();
        rst_n  = 1'b1;
        enable = 1'b0;

        // 2: 16-word stream at full rate.
        for (int i = 1; i <= 16; i++) push(DATA_W'(i));
        cyc();
        enable    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t2_fifo_rd", fifo_rd, (i < 16));
            chk("t2_valid", out_valid, (i >= 2 && i < 18));
        end
        chk("t2_cnt", word_cnt, 16);
        chk("t2_left", exp_q.size(), 0);

        // 3: backpressure, only two reads may be outstanding.
        cyc();
        enable    = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(DATA_W'(i));
        cyc();
        enable = 1'b1;
        r0 = n_reads;
        repeat (10) @(negedge clk);
        chk("t3_reads", n_reads - r0, 2);
        chk("t3_data", out_data, 10'h001);
        chk("t3_valid", out_valid, 1);
        chk("t3_busy", busy, 1);
        cyc();
        out_ready = 1'b1;
        wait_drain(60);
        chk("t3_cnt", word_cnt, 24);

        // 4: pop and capture in the same cycle keep one entry.
        cyc();
        enable = 1'b0;
        push(10'h2A5);
        push(10'h15A);
        cyc();
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_valid0", out_valid, 1);
        chk("t4_data0", out_data, 10'h2A5);
        @(negedge clk);
        chk("t4_valid1", out_valid, 1);
        chk("t4_data1", out_data, 10'h15A);
        chk("t4_busy1", busy, 1);
        @(negedge clk);
        chk("t4_valid2", out_valid, 0);
        chk("t4_busy2", busy, 0);

        // 5: enable dropped right after a read.
        cyc();
        enable = 1'b0;
        for (int i = 1; i <= 4; i++) push(DATA_W'(10'h0C0 + i));
        cyc();
        enable = 1'b1;
        r0 = n_reads;
        w0 = word_cnt;
        cyc();
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_no_rd", fifo_rd, 0);
        end
        chk("t5_reads", n_reads - r0, 1);
        chk("t5_cnt", CNT_W'(word_cnt - w0), 1);
        chk("t5_left", exp_q.size(), 3);
        cyc();
        enable = 1'b1;
        wait_drain(40);

        // 6: reset mid-stream with buffered and in-flight words.
        cyc();
        enable    = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(DATA_W'(10'h3F0 + i));
        cyc();
        enable = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_busy", busy, 1);
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cnt", word_cnt, 0);
        cyc();
        for (int i = 0; i < 3; i++) push(DATA_W'(10'h100 + i));
        wait_drain(40);
        chk("t6_cnt_after", word_cnt, 3);

        // 7: randomized traffic, enable and backpressure.
        for (int i = 0; i < 400; i++) begin
            cyc();
            if ($urandom_range(0, 2) != 0) push(DATA_W'($urandom_range(0, 1023)));
            out_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 4) != 0);
        end
        cyc();
        enable    = 1'b1;
        out_ready = 1'b1;
        wait_drain(800);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
